// File: rtl/mdio_cfg_seq.sv
// rtl/mdio_cfg_seq.sv - Marvell PHY power-up MDIO register-table sequencer with host pass-through
// Define MDIO_CFG_VERIFY_EN to add per-entry read-back verify with bounded retries.
module mdio_cfg_seq #(
    parameter logic [4:0] PHY_ADDR       = 5'd0,
    parameter int         NUM_ENTRIES    = 8,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter int         RETRY_MAX      = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    output logic [7:0]  o_tbl_addr,
    input  logic [20:0] i_tbl_entry,
    output logic        o_new_cmd,
    output logic [31:0] o_cmd,
    input  logic        i_rdy,
    input  logic [15:0] i_r_register_data,
    input  logic        i_host_req,
    input  logic [31:0] i_host_cmd,
    output logic        o_host_ack,
    output logic [15:0] o_host_rdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [7:0]  o_err_index
);
    localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      LAST_IDX = 8'(NUM_ENTRIES - 1);
    localparam logic [1:0]      OP_WR    = 2'b10;

    if (NUM_ENTRIES < 1 || NUM_ENTRIES > 256 || RETRY_MAX < 0) begin : g_param_check
        $error("mdio_cfg_seq: parameter out of range");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_ISSUE_WR, S_WAIT_WR,
`ifdef MDIO_CFG_VERIFY_EN
        S_ISSUE_RD, S_WAIT_RD, S_CHECK,
`endif
        S_NEXT, S_DONE, S_ERROR, S_HOST_ISSUE, S_HOST_WAIT
    } state_t;

    function automatic logic [31:0] mk_cmd(input logic [15:0] data, input logic [4:0] regad,
                                           input logic [1:0] op);
        return {data, 2'b01, regad, PHY_ADDR, op, 2'b10};
    endfunction

    state_t        state_q, state_d;
    logic [7:0]    idx_q, idx_d;
    logic [31:0]   cmd_q, cmd_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          seen_low_q, seen_low_d;
    logic          fetch_ph_q, fetch_ph_d;
    logic          busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [7:0]    err_idx_q, err_idx_d;
    logic          ack_q, ack_d;
    logic [15:0]   host_rdata_q, host_rdata_d;
    logic          start_pend_q, start_pend_d;
    logic          ret_err_q, ret_err_d;
    logic          new_cmd, go, fail, wait_done, wait_expired;
`ifdef MDIO_CFG_VERIFY_EN
    localparam int RW = $clog2(RETRY_MAX + 2);
    localparam logic [1:0] OP_RD = 2'b01;
    logic [4:0]    reg_q, reg_d;
    logic [15:0]   data_q, data_d, rd_q, rd_d;
    logic [RW-1:0] retry_q, retry_d;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cmd_q        <= '0;
            tmo_q        <= '0;
            seen_low_q   <= 1'b0;
            fetch_ph_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_idx_q    <= '0;
            ack_q        <= 1'b0;
            host_rdata_q <= '0;
            start_pend_q <= 1'b0;
            ret_err_q    <= 1'b0;
`ifdef MDIO_CFG_VERIFY_EN
            reg_q        <= '0;
            data_q       <= '0;
            rd_q         <= '0;
            retry_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cmd_q        <= cmd_d;
            tmo_q        <= tmo_d;
            seen_low_q   <= seen_low_d;
            fetch_ph_q   <= fetch_ph_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_idx_q    <= err_idx_d;
            ack_q        <= ack_d;
            host_rdata_q <= host_rdata_d;
            start_pend_q <= start_pend_d;
            ret_err_q    <= ret_err_d;
`ifdef MDIO_CFG_VERIFY_EN
            reg_q        <= reg_d;
            data_q       <= data_d;
            rd_q         <= rd_d;
            retry_q      <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cmd_d        = cmd_q;
        tmo_d        = tmo_q + 1'b1;
        seen_low_d   = seen_low_q | ~i_rdy;
        fetch_ph_d   = fetch_ph_q;
        busy_d       = busy_q;
        done_d       = done_q;
        error_d      = error_q;
        err_idx_d    = err_idx_q;
        ack_d        = 1'b0;
        host_rdata_d = host_rdata_q;
        start_pend_d = start_pend_q;
        ret_err_d    = ret_err_q;
`ifdef MDIO_CFG_VERIFY_EN
        reg_d        = reg_q;
        data_d       = data_q;
        rd_d         = rd_q;
        retry_d      = retry_q;
`endif
        new_cmd      = 1'b0;
        go           = 1'b0;
        fail         = 1'b0;
        // A master transaction is complete once i_rdy has dropped and come back.
        wait_done    = seen_low_q & i_rdy;
        wait_expired = (tmo_q == TMO_LAST);
        case (state_q)
            S_IDLE: go = i_start;
            S_FETCH: begin
                fetch_ph_d = ~fetch_ph_q;
                if (fetch_ph_q) begin
                    cmd_d   = mk_cmd(i_tbl_entry[15:0], i_tbl_entry[20:16], OP_WR);
                    state_d = S_ISSUE_WR;
`ifdef MDIO_CFG_VERIFY_EN
                    reg_d   = i_tbl_entry[20:16];
                    data_d  = i_tbl_entry[15:0];
                    retry_d = '0;
`endif
                end
            end
            S_ISSUE_WR: if (i_rdy) begin
                new_cmd = 1'b1; tmo_d = '0; seen_low_d = 1'b0; state_d = S_WAIT_WR;
            end
            S_WAIT_WR: begin
                if (wait_done) begin
`ifdef MDIO_CFG_VERIFY_EN
                    cmd_d   = mk_cmd(16'h0000, reg_q, OP_RD);
                    state_d = S_ISSUE_RD;
`else
                    state_d = S_NEXT;
`endif
                end else if (wait_expired) fail = 1'b1;
            end
`ifdef MDIO_CFG_VERIFY_EN
            S_ISSUE_RD: if (i_rdy) begin
                new_cmd = 1'b1; tmo_d = '0; seen_low_d = 1'b0; state_d = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (wait_done) begin
                    rd_d = i_r_register_data; state_d = S_CHECK;
                end else if (wait_expired) fail = 1'b1;
            end
            S_CHECK: begin
                if (rd_q == data_q) state_d = S_NEXT;
                else if (retry_q == RW'(RETRY_MAX)) fail = 1'b1;
                else begin
                    retry_d = retry_q + 1'b1;
                    cmd_d   = mk_cmd(data_q, reg_q, OP_WR);
                    state_d = S_ISSUE_WR;
                end
            end
`endif
            S_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE; busy_d = 1'b0; done_d = 1'b1;
                end else begin
                    idx_d = idx_q + 8'd1; fetch_ph_d = 1'b0; state_d = S_FETCH;
                end
            end
            S_DONE, S_ERROR: begin
                // Host request is masked during the ack cycle so one request yields one command.
                if (i_start || start_pend_q) go = 1'b1;
                else if (i_host_req && i_rdy && !ack_q) begin
                    cmd_d     = i_host_cmd;
                    ret_err_d = (state_q == S_ERROR);
                    state_d   = S_HOST_ISSUE;
                end
            end
            S_HOST_ISSUE: begin
                if (i_start) start_pend_d = 1'b1;
                if (i_rdy) begin
                    new_cmd = 1'b1; tmo_d = '0; seen_low_d = 1'b0; state_d = S_HOST_WAIT;
                end
            end
            S_HOST_WAIT: begin
                if (i_start) start_pend_d = 1'b1;
                if (wait_done || wait_expired) begin
                    host_rdata_d = wait_done ? i_r_register_data : 16'hFFFF;
                    ack_d        = 1'b1;
                    state_d      = ret_err_q ? S_ERROR : S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (go) begin
            state_d = S_FETCH; idx_d = '0; fetch_ph_d = 1'b0; busy_d = 1'b1;
            done_d = 1'b0; error_d = 1'b0; err_idx_d = '0; start_pend_d = 1'b0;
        end
        if (fail) begin
            state_d = S_ERROR; busy_d = 1'b0; error_d = 1'b1; err_idx_d = idx_q;
        end
    end

    assign o_tbl_addr   = idx_q;
    assign o_new_cmd    = new_cmd;
    assign o_cmd        = cmd_q;
    assign o_host_ack   = ack_q;
    assign o_host_rdata = host_rdata_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_error      = error_q;
    assign o_err_index  = err_idx_q;
endmodule
